dmem_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the single-port data memory shared by the core and other

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for a shared single-port data memory.
// Requesters are served one access at a time. Each access is range-checked
// against DEPTH. Read data is returned with a per-requester rvalid pulse.
module dmem_arbiter #(
    parameter int NREQ  = 2,
    parameter int DW    = 16,
    parameter int AW    = 5,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      err,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int          SW      = $clog2(NREQ);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   sel;
    logic            sel_we;
    logic            sel_oor;

    logic            win_found;
    logic [SW-1:0]   win;
    logic [SW-1:0]   cand;
    logic            win_we;
    logic            win_oor;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester above the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win       = rr_ptr;
        cand      = '0;
        for (int s = 1; s <= NREQ; s++) begin
            cand = SW'((int'(rr_ptr) + s) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    assign win_we    = we[win];
    assign win_addr  = addr[win*AW +: AW];
    assign win_wdata = wdata[win*DW +: DW];
    // Only the AW address bits are checked; no folding into DEPTH.
    assign win_oor   = ({1'b0, win_addr} >= DEPTH_V);

    // Access sequencer. All outputs are registered pulses that default to 0.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= SW'(NREQ-1);
            sel       <= '0;
            sel_we    <= 1'b0;
            sel_oor   <= 1'b0;
            gnt       <= '0;
            err       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt       <= '0;
            err       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        sel     <= win;
                        rr_ptr  <= win;
                        sel_we  <= win_we;
                        sel_oor <= win_oor;
                        gnt     <= onehot(win);
                        if (win_oor) begin
                            err <= onehot(win);
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= win_we;
                            mem_addr  <= win_addr;
                            mem_wdata <= win_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes are done once the memory has seen the strobe.
                    state <= sel_we ? IDLE : RDATA;
                end
                RDATA: begin
                    rdata  <= sel_oor ? '0 : mem_rdata;
                    rvalid <= onehot(sel);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;
    localparam int NREQ  = 2;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  req, we, gnt, err, rvalid;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;

    dmem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory attached to the arbiter's port.
    logic [15:0] tb_mem [32];
    logic        fill;

    function automatic logic [15:0] init_val(input int k);
        return (k == 3) ? 16'hA5A5 : 16'(k * 16'h1111 + 16'h0123);
    endfunction

    // Synchronous-read memory; first clock fills it with a known pattern.
    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 32; k++) tb_mem[k] <= init_val(k);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    logic        pend    [NREQ];
    logic        p_we    [NREQ];
    logic [4:0]  p_addr  [NREQ];
    logic [15:0] p_wdata [NREQ];
    logic [1:0]  e_gnt [8], e_err [8], e_rv [8];
    logic [15:0] e_rd  [8], e_wdata [8];
    logic        e_en  [8], e_we [8];
    logic [4:0]  e_addr [8];
    int compared, mismatched, cyc, free_at, last, ngrants;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_slot(input int s);
        e_gnt[s] = '0; e_err[s] = '0; e_rv[s] = '0; e_rd[s] = '0;
        e_en[s] = 1'b0; e_we[s] = 1'b0; e_addr[s] = '0; e_wdata[s] = '0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) clear_slot(s);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req     = '0;
        last    = NREQ - 1;
        free_at = cyc;
    endtask

    task automatic post(input int i, input logic w, input logic [4:0] a, input logic [15:0] d);
        pend[i] = 1'b1; p_we[i] = w; p_addr[i] = a; p_wdata[i] = d;
        req[i] = 1'b1; we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
    endtask

    // Model one accepted access: what the port shows now and two cycles later.
    task automatic grant(input int w);
        int  s, s2;
        logic oor;
        s   = cyc % 8;
        oor = (p_addr[w] >= 5'(DEPTH));
        e_gnt[s] = 2'(1 << w);
        if (oor) e_err[s] = 2'(1 << w);
        else begin
            e_en[s] = 1'b1; e_we[s] = p_we[w]; e_addr[s] = p_addr[w]; e_wdata[s] = p_wdata[w];
        end
        if (p_we[w]) begin
            if (!oor) ref_mem[p_addr[w]] = p_wdata[w];
            free_at = cyc + 2;
        end else begin
            s2 = (cyc + 2) % 8;
            e_rv[s2] = 2'(1 << w);
            e_rd[s2] = oor ? 16'h0 : ref_mem[p_addr[w]];
            free_at = cyc + 3;
        end
        last = w;
        ngrants++;
    endtask

    task automatic step();
        int w, s;
        w = -1;
        @(posedge clk);
        cyc++;
        if (cyc >= free_at) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (last + k) % NREQ;
                if (w < 0 && pend[i]) w = i;
            end
        end
        if (w >= 0) grant(w);
        @(negedge clk);
        s = cyc % 8;
        check("gnt", 32'(gnt), 32'(e_gnt[s]));
        check("err", 32'(err), 32'(e_err[s]));
        check("rvalid", 32'(rvalid), 32'(e_rv[s]));
        if (e_rv[s] != 2'b00) check("rdata", 32'(rdata), 32'(e_rd[s]));
        check("mem_en", 32'(mem_en), 32'(e_en[s]));
        check("mem_we", 32'(mem_we), 32'(e_we[s]));
        check("mem_addr", 32'(mem_addr), 32'(e_addr[s]));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata[s]));
        clear_slot(s);
        if (w >= 0) begin
            pend[w] = 1'b0;
            req[w]  = 1'b0;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((pend[0] || pend[1] || cyc < free_at) && b < 60) begin
            step();
            b++;
        end
        check("drain_timeout", 32'(b < 60), 32'd1);
    endtask

    task automatic wait_grant();
        int g0, b;
        g0 = ngrants;
        b  = 0;
        while (ngrants == g0 && b < 40) begin
            step();
            b++;
        end
        check("grant_timeout", 32'(ngrants != g0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // Asynchronous reset pulse started just after a falling edge.
    task automatic reset_pulse(input string tag);
        #1 sys_rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0; ngrants = 0;
        fill = 1'b1;
        sys_rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_val(k);
        model_reset();
        @(posedge clk);
        #1 fill = 1'b0;
        #6 check_all_zero("reset");
        @(negedge clk);
        sys_rst_n = 1'b1;

        // 1: single read of a preloaded word
        post(0, 1'b0, 5'd3, 16'h0000);
        drain();

        // 2: simultaneous writes after reset, requester 0 first
        reset_pulse("rst_idle");
        post(0, 1'b1, 5'd1, 16'h1111);
        post(1, 1'b1, 5'd2, 16'h2222);
        drain();
        check("mem1", 32'(tb_mem[1]), 32'h1111);
        check("mem2", 32'(tb_mem[2]), 32'h2222);

        // 3: both requesters hold read requests for eight grants
        begin
            int g0, b;
            g0 = ngrants;
            b  = 0;
            post(0, 1'b0, 5'(($urandom % 16)), 16'h0);
            post(1, 1'b0, 5'(($urandom % 16)), 16'h0);
            while (ngrants - g0 < 8 && b < 100) begin
                step();
                b++;
                if (ngrants - g0 < 7) begin
                    for (int i = 0; i < NREQ; i++)
                        if (!pend[i]) post(i, 1'b0, 5'(($urandom % 16)), 16'h0);
                end
            end
            check("rr_timeout", 32'(ngrants - g0 >= 8), 32'd1);
            drain();
        end

        // 4: out-of-range read
        post(1, 1'b0, 5'd16, 16'h0);
        drain();

        // 5a: reset while a read is in its grant cycle
        post(0, 1'b0, 5'd5, 16'h0);
        wait_grant();
        reset_pulse("rst_access");
        repeat (4) step();

        // 5b: reset while a read waits for its data; then both request
        post(1, 1'b0, 5'd6, 16'h0);
        wait_grant();
        step();
        reset_pulse("rst_rdata");
        repeat (4) step();
        post(0, 1'b1, 5'd9, 16'h0909);
        post(1, 1'b1, 5'd10, 16'h1010);
        drain();

        // 6: write by requester 1 then read back by requester 0
        post(1, 1'b1, 5'd7, 16'hBEEF);
        wait_grant();
        post(0, 1'b0, 5'd7, 16'h0);
        drain();

        // Random traffic including out-of-range addresses and withdrawals
        for (int n = 0; n < 600; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        post(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
                             16'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end
            end
        end
        drain();

        for (int k = 0; k < DEPTH; k++) check("mem_final", 32'(tb_mem[k]), 32'(ref_mem[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
